// File: rtl/ring_slide_sequencer.sv
// Central sequencer for the inter-cluster slide ring.
// Accepts one slide command at a time, drives every ring router's direction and bypass,
// lets the routers settle, then counts per-cluster transmit/receive beats until the whole
// ring has drained and returns a single completion response (with a sticky error flag).
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_dir_i                0 = slidedown (left), 1 = slideup (right)
//   cmd_beats_i              beats each active cluster sends and receives
//   cmd_bypass_i             per-cluster exclusion mask (router forwards only)
//   sldu_dir_o, bypass_o     per-router configuration
//   traffic_en_o             clusters may inject ring beats
//   tx_fire_i, rx_fire_i     per-cluster beat handshakes observed this cycle
//   done_valid_o/done_ready_i completion handshake, qualified by done_err_o
//   busy_o                   sequencer is not idle
module ring_slide_sequencer #(
  parameter int unsigned NrClusters   = 4,
  parameter int unsigned BeatWidth    = 16,
  parameter int unsigned SettleCycles = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_dir_i,
  input  logic [BeatWidth-1:0]  cmd_beats_i,
  input  logic [NrClusters-1:0] cmd_bypass_i,
  output logic [NrClusters-1:0] sldu_dir_o,
  output logic [NrClusters-1:0] bypass_o,
  output logic                  traffic_en_o,
  input  logic [NrClusters-1:0] tx_fire_i,
  input  logic [NrClusters-1:0] rx_fire_i,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic                  done_err_o,
  output logic                  busy_o
);

  localparam int unsigned SettleW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  typedef enum logic [1:0] {StIdle, StConfig, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [NrClusters-1:0]   sldu_dir_q, sldu_dir_d;
  logic [NrClusters-1:0]   bypass_q, bypass_d;
  logic [BeatWidth-1:0]    beats_q, beats_d;
  logic [SettleW-1:0]      settle_q, settle_d;
  logic [BeatWidth-1:0]    tx_cnt_q [NrClusters];
  logic [BeatWidth-1:0]    tx_cnt_d [NrClusters];
  logic [BeatWidth-1:0]    rx_cnt_q [NrClusters];
  logic [BeatWidth-1:0]    rx_cnt_d [NrClusters];
  logic                    err_q, err_d;
  logic                    all_complete;

  // Completion uses registered counts only; fires in the completing cycle are checked
  // for errors but do not delay the decision.
  always_comb begin
    all_complete = 1'b1;
    for (int c = 0; c < NrClusters; c++) begin
      if (!bypass_q[c] && !(tx_cnt_q[c] == beats_q && rx_cnt_q[c] == beats_q)) begin
        all_complete = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sldu_dir_d   = sldu_dir_q;
    bypass_d     = bypass_q;
    beats_d      = beats_q;
    settle_d     = settle_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    err_d        = err_q;
    cmd_ready_o  = 1'b0;
    traffic_en_o = 1'b0;
    done_valid_o = 1'b0;
    done_err_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        // Fires seen while idle belong to no command and must not taint the next one.
        err_d       = 1'b0;
        if (cmd_valid_i) begin
          sldu_dir_d = {NrClusters{cmd_dir_i}};
          bypass_d   = cmd_bypass_i;
          beats_d    = cmd_beats_i;
          settle_d   = SettleW'(SettleCycles - 1);
          state_d    = StConfig;
        end
      end
      StConfig: begin
        if ((tx_fire_i | rx_fire_i) != '0) err_d = 1'b1;
        if (settle_q == '0) begin
          state_d = (beats_q == '0 || &bypass_q) ? StDone : StRun;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StRun: begin
        traffic_en_o = !all_complete;
        if (all_complete) state_d = StDone;
        // An erroneous fire (bypassed cluster or counter already at beats) is flagged but
        // not counted, so an overrun cannot prevent the ring from completing.
        for (int c = 0; c < NrClusters; c++) begin
          if (tx_fire_i[c]) begin
            if (bypass_q[c] || tx_cnt_q[c] >= beats_q) err_d = 1'b1;
            else if (tx_cnt_q[c] != '1) tx_cnt_d[c] = tx_cnt_q[c] + 1'b1;
          end
          if (rx_fire_i[c]) begin
            if (bypass_q[c] || rx_cnt_q[c] >= beats_q) err_d = 1'b1;
            else if (rx_cnt_q[c] != '1) rx_cnt_d[c] = rx_cnt_q[c] + 1'b1;
          end
        end
      end
      StDone: begin
        // Error flag is frozen here so done_err_o stays stable until consumed.
        done_valid_o = 1'b1;
        done_err_o   = err_q;
        if (done_ready_i) begin
          state_d = StIdle;
          err_d   = 1'b0;
          for (int c = 0; c < NrClusters; c++) begin
            tx_cnt_d[c] = '0;
            rx_cnt_d[c] = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sldu_dir_q <= '0;
      bypass_q   <= '0;
      beats_q    <= '0;
      settle_q   <= '0;
      err_q      <= 1'b0;
      for (int c = 0; c < NrClusters; c++) begin
        tx_cnt_q[c] <= '0;
        rx_cnt_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sldu_dir_q <= sldu_dir_d;
      bypass_q   <= bypass_d;
      beats_q    <= beats_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign sldu_dir_o = sldu_dir_q;
  assign bypass_o   = bypass_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_ring_slide_sequencer.sv
// Self-checking bench for ring_slide_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_ring_slide_sequencer;

  localparam int N   = 4;
  localparam int BW  = 16;
  localparam int SET = 2;

  localparam int PhIdle = 0;
  localparam int PhCfg  = 1;
  localparam int PhRun  = 2;
  localparam int PhDone = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_dir_i = 1'b0;
  logic [BW-1:0] cmd_beats_i = '0;
  logic [N-1:0]  cmd_bypass_i = '0;
  logic [N-1:0]  sldu_dir_o;
  logic [N-1:0]  bypass_o;
  logic          traffic_en_o;
  logic [N-1:0]  tx_fire_i = '0;
  logic [N-1:0]  rx_fire_i = '0;
  logic          done_valid_o;
  logic          done_ready_i = 1'b0;
  logic          done_err_o;
  logic          busy_o;

  always #5 clk = ~clk;

  ring_slide_sequencer #(
    .NrClusters  (N),
    .BeatWidth   (BW),
    .SettleCycles(SET)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_dir_i   (cmd_dir_i),
    .cmd_beats_i (cmd_beats_i),
    .cmd_bypass_i(cmd_bypass_i),
    .sldu_dir_o  (sldu_dir_o),
    .bypass_o    (bypass_o),
    .traffic_en_o(traffic_en_o),
    .tx_fire_i   (tx_fire_i),
    .rx_fire_i   (rx_fire_i),
    .done_valid_o(done_valid_o),
    .done_ready_i(done_ready_i),
    .done_err_o  (done_err_o),
    .busy_o      (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_phase = PhIdle;
  int           m_cfg_left = 0;
  int           m_beats = 0;
  int           m_tx [N];
  int           m_rx [N];
  logic [N-1:0] m_byp = '0;
  logic [N-1:0] m_dir_out = '0;
  logic         m_err = 1'b0;
  bit           m_live = 1'b0;

  function automatic bit m_all_done();
    for (int c = 0; c < N; c++) begin
      if (!m_byp[c] && !(m_tx[c] == m_beats && m_rx[c] == m_beats)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_clear_counts();
    for (int c = 0; c < N; c++) begin
      m_tx[c] = 0;
      m_rx[c] = 0;
    end
  endtask

  task automatic model_step();
    bit fin;
    if (rst_i) begin
      m_phase = PhIdle; m_err = 1'b0; m_byp = '0; m_dir_out = '0; m_beats = 0;
      m_clear_counts();
      m_live = 1'b1;
      return;
    end
    if (!m_live) return;
    case (m_phase)
      PhIdle: begin
        m_err = 1'b0;
        if (cmd_valid_i) begin
          m_beats    = int'(cmd_beats_i);
          m_byp      = cmd_bypass_i;
          m_dir_out  = {N{cmd_dir_i}};
          m_cfg_left = SET;
          m_phase    = PhCfg;
        end
      end
      PhCfg: begin
        if ((tx_fire_i | rx_fire_i) != '0) m_err = 1'b1;
        m_cfg_left--;
        if (m_cfg_left == 0) m_phase = (m_beats == 0 || m_byp == '1) ? PhDone : PhRun;
      end
      PhRun: begin
        fin = m_all_done();
        for (int c = 0; c < N; c++) begin
          if (tx_fire_i[c]) begin
            if (m_byp[c] || m_tx[c] >= m_beats) m_err = 1'b1;
            else m_tx[c]++;
          end
          if (rx_fire_i[c]) begin
            if (m_byp[c] || m_rx[c] >= m_beats) m_err = 1'b1;
            else m_rx[c]++;
          end
        end
        if (fin) m_phase = PhDone;
      end
      default: begin
        if (done_ready_i) begin
          m_phase = PhIdle;
          m_err   = 1'b0;
          m_clear_counts();
        end
      end
    endcase
  endtask

  initial begin
    m_clear_counts();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("cmd_ready", 32'(cmd_ready_o), 32'(m_phase == PhIdle));
        check("sldu_dir", 32'(sldu_dir_o), 32'(m_dir_out));
        check("bypass", 32'(bypass_o), 32'(m_byp));
        check("traffic_en", 32'(traffic_en_o), 32'(m_phase == PhRun && !m_all_done()));
        check("done_valid", 32'(done_valid_o), 32'(m_phase == PhDone));
        check("done_err", 32'(done_err_o), 32'(m_phase == PhDone && m_err));
        check("busy", 32'(busy_o), 32'(m_phase != PhIdle));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic dir, input int beats, input logic [N-1:0] byp);
    cmd_valid_i  = 1'b1;
    cmd_dir_i    = dir;
    cmd_beats_i  = BW'(beats);
    cmd_bypass_i = byp;
    tick();
    cmd_valid_i  = 1'b0;
  endtask

  task automatic consume_done();
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done_valid_o && n < max_cycles) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_valid_o), 32'd1);
  endtask

  logic [N-1:0] rx_pat [4];
  int r;

  initial begin
    tick();
    tick();
    check("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;

    // Slideup, beats=3, all clusters fire every cycle.
    send_cmd(1'b1, 3, 4'b0000);                              // now cycle 1
    check("up_dir", 32'(sldu_dir_o), 32'hF);
    check("up_cfg_traffic", 32'(traffic_en_o), 32'd0);
    tick();                                                  // cycle 2
    check("up_cfg2_traffic", 32'(traffic_en_o), 32'd0);
    tick();                                                  // cycle 3
    check("up_traffic_start", 32'(traffic_en_o), 32'd1);
    tx_fire_i = 4'hF; rx_fire_i = 4'hF;
    tick(); tick(); tick();                                  // cycle 6
    tx_fire_i = '0; rx_fire_i = '0;
    check("up_traffic_stop", 32'(traffic_en_o), 32'd0);
    check("up_not_done_yet", 32'(done_valid_o), 32'd0);
    tick();                                                  // cycle 7
    check("up_done", 32'(done_valid_o), 32'd1);
    check("up_err", 32'(done_err_o), 32'd0);
    consume_done();
    check("up_idle_ready", 32'(cmd_ready_o), 32'd1);

    // Slidedown, beats=2, cluster 2 bypassed, staggered rx.
    rx_pat[0] = 4'b0001; rx_pat[1] = 4'b0011; rx_pat[2] = 4'b1010; rx_pat[3] = 4'b1000;
    send_cmd(1'b0, 2, 4'b0100);
    check("down_dir", 32'(sldu_dir_o), 32'h0);
    check("down_bypass", 32'(bypass_o), 32'h4);
    tick(); tick();                                          // cycle 3
    for (int i = 0; i < 4; i++) begin
      tx_fire_i = (i < 2) ? 4'b1011 : 4'b0000;
      rx_fire_i = rx_pat[i];
      if (i == 3) check("down_still_running", 32'(traffic_en_o), 32'd1);
      tick();
    end                                                      // cycle 7
    tx_fire_i = '0; rx_fire_i = '0;
    check("down_traffic_stop", 32'(traffic_en_o), 32'd0);
    check("down_not_done", 32'(done_valid_o), 32'd0);
    tick();
    check("down_done", 32'(done_valid_o), 32'd1);
    check("down_err", 32'(done_err_o), 32'd0);
    consume_done();

    // Spurious idle fire, then beats=0: done exactly SET+1 cycles after accept, no error.
    tx_fire_i = 4'b0010;
    tick();
    tx_fire_i = '0;
    send_cmd(1'b1, 0, 4'b0000);                              // cycle 1
    tick();                                                  // cycle 2
    check("zero_not_done", 32'(done_valid_o), 32'd0);
    tick();                                                  // cycle 3
    check("zero_done", 32'(done_valid_o), 32'd1);
    check("zero_err", 32'(done_err_o), 32'd0);
    check("zero_no_traffic", 32'(traffic_en_o), 32'd0);
    consume_done();

    // Overrun on cluster 1 -> error reported at completion.
    send_cmd(1'b1, 1, 4'b0000);
    tick(); tick();                                          // cycle 3
    tx_fire_i = 4'hF; rx_fire_i = 4'hF;
    tick();                                                  // cycle 4
    tx_fire_i = 4'b0010; rx_fire_i = '0;
    tick();                                                  // cycle 5
    tx_fire_i = '0;
    check("ovr_done", 32'(done_valid_o), 32'd1);
    check("ovr_err", 32'(done_err_o), 32'd1);

    // Hold done while a new command is offered.
    cmd_valid_i = 1'b1; cmd_dir_i = 1'b0; cmd_beats_i = '0; cmd_bypass_i = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_done", 32'(done_valid_o), 32'd1);
      check("hold_err", 32'(done_err_o), 32'd1);
      check("hold_ready", 32'(cmd_ready_o), 32'd0);
    end
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    check("hold_ready_after", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    check("hold_accepted", 32'(busy_o), 32'd1);
    wait_done(10);
    check("hold_cmd_err", 32'(done_err_o), 32'd0);
    consume_done();

    // Reset mid-RUN with counters at 1 of 3.
    send_cmd(1'b1, 3, 4'b0000);
    tick(); tick();
    tx_fire_i = 4'hF; rx_fire_i = 4'hF;
    tick();
    tx_fire_i = '0; rx_fire_i = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_traffic", 32'(traffic_en_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_dir", 32'(sldu_dir_o), 32'd0);
    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    send_cmd(1'b1, 1, 4'b0000);
    tick(); tick();
    tx_fire_i = 4'hF; rx_fire_i = 4'hF;
    tick();
    tx_fire_i = '0; rx_fire_i = '0;
    wait_done(10);
    check("rst_new_err", 32'(done_err_o), 32'd0);
    consume_done();

    // Randomized traffic checked every cycle by the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_i        = ($urandom_range(0, 299) == 0);
      cmd_valid_i  = ($urandom_range(0, 3) == 0);
      cmd_dir_i    = 1'($urandom);
      cmd_beats_i  = BW'($urandom_range(0, 4));
      r            = int'($urandom_range(0, 7));
      cmd_bypass_i = (r == 0) ? 4'hF : (r < 3) ? 4'($urandom) : 4'h0;
      done_ready_i = ($urandom_range(0, 2) == 0);
      tx_fire_i    = '0;
      rx_fire_i    = '0;
      if (m_phase == PhRun) begin
        for (int c = 0; c < N; c++) begin
          if (!m_byp[c] && m_tx[c] < m_beats && $urandom_range(0, 1) == 1) tx_fire_i[c] = 1'b1;
          if (!m_byp[c] && m_rx[c] < m_beats && $urandom_range(0, 1) == 1) rx_fire_i[c] = 1'b1;
        end
      end
      if ($urandom_range(0, 40) == 0) tx_fire_i[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 40) == 0) rx_fire_i[$urandom_range(0, N - 1)] = 1'b1;
      tick();
    end

    rst_i = 1'b0; cmd_valid_i = 1'b0; tx_fire_i = '0; rx_fire_i = '0; done_ready_i = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
